key_debouncer: RTL and testbench

- Upstream conditioning stage for the board push-buttons (KEY[3:0], active-low, bouncy, asynchronous to CLOCK_50).
- Produces clean per-key debounced levels plus one-cycle press, release and long-press pulses.
- Outputs feed the LED/blink controllers directly, so they no longer sample raw KEY inputs.

---
 rtl/key_debouncer.sv | 136 +++++++++++++
 tb/tb_key_debouncer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchronizer plus a per-key debounce FSM that
// produces clean levels and one-cycle press / release / long-press pulses.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LCNT_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LONG_MAX = LCNT_W'(LONG_CYCLES);
  localparam logic [LCNT_W-1:0] LONG_PRE = LCNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  // Sync flops reset to 1 so a held key reads as released until re-sampled.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [LCNT_W-1:0]   r_lcnt, w_lcnt_nxt;
    logic                r_level, r_press, r_release, r_long;
    logic                w_level_nxt, w_press_nxt, w_release_nxt, w_long_nxt;
    logic                w_s, w_accept_press, w_accept_release, w_lcnt_inc;

    assign w_s              = r_sync2[g];
    assign w_accept_press   = (r_state == PRESS_WAIT) && !w_s && (r_cnt == DB_LAST);
    assign w_accept_release = (r_state == RELEASE_WAIT) && w_s && (r_cnt == DB_LAST);
    // Hold time keeps accumulating while bouncing toward release, but stops
    // on the edge the release is accepted so key_long never trails key_release.
    assign w_lcnt_inc = (r_lcnt != LONG_MAX) &&
                        (((r_state == PRESSED) && !w_s) ||
                         ((r_state == RELEASE_WAIT) && !w_accept_release));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_lcnt    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_lcnt    <= w_lcnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_long    <= w_long_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lcnt_nxt  = w_lcnt_inc ? r_lcnt + LCNT_W'(1) : r_lcnt;
      unique case (r_state)
        IDLE: begin
          if (!w_s) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (w_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_accept_press) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
            w_lcnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (w_s) begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!w_s) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else if (w_accept_release) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      w_level_nxt   = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
      w_press_nxt   = w_accept_press;
      w_release_nxt = w_accept_release;
      w_long_nxt    = w_lcnt_inc && (r_lcnt == LONG_PRE);
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with short debounce/long-press windows.
module tb_key_debouncer;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [3:0] KEY      = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_long;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt[4];
  int rel_cnt[4];
  int long_cnt[4];
  int busy_cnt = 0;

  key_debouncer #(.N_KEYS(4), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulse tallies sampled on the falling edge.
  initial for (int i = 0; i < 4; i++) begin
    press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
  end
  always @(negedge CLOCK_50) begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] += int'(key_press[i]);
      rel_cnt[i]   += int'(key_release[i]);
      long_cnt[i]  += int'(key_long[i]);
    end
    if ((key_level | key_press | key_release | key_long) != 4'h0) busy_cnt++;
  end

  typedef struct {
    logic [3:0] key;
    int         edges;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs[15];

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [3:0] lng);
    chk({name, " level"},   32'(key_level),   32'(lvl));
    chk({name, " press"},   32'(key_press),   32'(prs));
    chk({name, " release"}, 32'(key_release), 32'(rel));
    chk({name, " long"},    32'(key_long),    32'(lng));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lb;
    // KEY[0] clean press and release, then KEY[1] bounce followed by a clean press.
    vecs[0]  = '{4'hE, 9,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{4'hE, 1,  4'h1, 4'h1, 4'h0, 4'h0};
    vecs[2]  = '{4'hE, 1,  4'h1, 4'h0, 4'h0, 4'h0};
    vecs[3]  = '{4'hF, 9,  4'h1, 4'h0, 4'h0, 4'h0};
    vecs[4]  = '{4'hF, 1,  4'h0, 4'h0, 4'h1, 4'h0};
    vecs[5]  = '{4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[6]  = '{4'hD, 3,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{4'hF, 2,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{4'hD, 5,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[9]  = '{4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[10] = '{4'hD, 9,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[11] = '{4'hD, 1,  4'h2, 4'h2, 4'h0, 4'h0};
    vecs[12] = '{4'hD, 1,  4'h2, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{4'hF, 10, 4'h0, 4'h0, 4'h2, 4'h0};
    vecs[14] = '{4'hF, 2,  4'h0, 4'h0, 4'h0, 4'h0};

    #2;
    chk_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    step(2);
    RESET_N = 1'b1;

    step(50);
    chk("idle quiet cycles", 32'(busy_cnt), 32'd0);
    chk_out("idle", 4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < 15; i++) begin
      KEY = vecs[i].key;
      step(vecs[i].edges);
      chk_out($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lng);
    end
    chk("key1 press count", 32'(press_cnt[1]), 32'd1);
    chk("key0 press count", 32'(press_cnt[0]), 32'd1);

    // KEY[2] long hold
    KEY = 4'hB;
    step(10);
    chk_out("long press", 4'h4, 4'h4, 4'h0, 4'h0);
    lb = long_cnt[2];
    step(31);
    chk_out("long pre", 4'h4, 4'h0, 4'h0, 4'h0);
    step(1);
    chk_out("long fire", 4'h4, 4'h0, 4'h0, 4'h4);
    step(1);
    chk_out("long after", 4'h4, 4'h0, 4'h0, 4'h0);
    step(27);
    chk("long once", 32'(long_cnt[2] - lb), 32'd1);
    KEY = 4'hF;
    step(9);
    chk_out("long rel pre", 4'h4, 4'h0, 4'h0, 4'h0);
    step(1);
    chk_out("long rel", 4'h0, 4'h0, 4'h4, 4'h0);
    step(2);
    chk("long total", 32'(long_cnt[2] - lb), 32'd1);

    // KEY[0] and KEY[3] together, release KEY[3] only
    KEY = 4'h6;
    step(9);
    chk_out("dual pre", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1);
    chk_out("dual press", 4'h9, 4'h9, 4'h0, 4'h0);
    step(1);
    KEY = 4'hE;
    step(9);
    chk_out("k3 rel pre", 4'h9, 4'h0, 4'h0, 4'h0);
    step(1);
    chk_out("k3 rel", 4'h1, 4'h0, 4'h8, 4'h0);
    step(1);
    KEY = 4'hF;
    step(10);
    chk_out("k0 rel", 4'h0, 4'h0, 4'h1, 4'h0);
    step(2);

    // Reset in the middle of a KEY[1] press
    KEY = 4'hD;
    step(10);
    chk_out("rst press", 4'h2, 4'h2, 4'h0, 4'h0);
    step(2);
    #2 RESET_N = 1'b0;
    #1;
    chk_out("async reset", 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge CLOCK_50);
    #1 RESET_N = 1'b1;
    step(9);
    chk_out("post rst pre", 4'h0, 4'h0, 4'h0, 4'h0);
    step(1);
    chk_out("post rst press", 4'h2, 4'h2, 4'h0, 4'h0);
    KEY = 4'hF;
    step(12);
    chk_out("final", 4'h0, 4'h0, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
